// File: rtl/ula_issue_queue_if.sv
// Bundle between the ULA issue queue and its neighbours: producer, ULA and result consumer.
// slave is the queue's own view; master is the environment driving it.
interface ula_issue_queue_if #(parameter int DEPTH = 4);
  logic                     in_valid;
  logic                     in_ready;
  logic [15:0]              in_A;
  logic [15:0]              in_B;
  logic [1:0]               in_instru;
  logic [15:0]              A;
  logic [15:0]              B;
  logic [1:0]               instru;
  logic                     valid_ula;
  logic [31:0]              data_out;
  logic                     valid_out;
  logic                     res_valid;
  logic [31:0]              res_data;
  logic [1:0]               res_instru;
  logic                     res_ready;
  logic                     timeout_err;
  logic [$clog2(DEPTH):0]   count;

  modport slave (
    input  in_valid, in_A, in_B, in_instru, data_out, valid_out, res_ready,
    output in_ready, A, B, instru, valid_ula, res_valid, res_data, res_instru,
           timeout_err, count
  );

  modport master (
    output in_valid, in_A, in_B, in_instru, data_out, valid_out, res_ready,
    input  in_ready, A, B, instru, valid_ula, res_valid, res_data, res_instru,
           timeout_err, count
  );
endinterface

// File: rtl/ula_issue_queue.sv
// Small operation FIFO feeding the ULA one op at a time; captures and holds each
// tagged result for a consumer, and drops ops the ULA never answers.
module ula_issue_queue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input logic                clk_ula,
  input logic                rst,
  ula_issue_queue_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
  } op_t;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, GAP} state_t;

  op_t           mem [DEPTH];
  op_t           head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic [7:0]    timer;
  state_t        state, state_nx;
  logic          push, pop, load, capture, abort;

  // Full blocks the producer even if the head is popped this cycle.
  assign bus.in_ready  = (cnt != CW'(DEPTH));
  assign bus.count     = cnt;
  assign bus.valid_ula = (state == ISSUE);
  assign bus.res_valid = (state == HOLD);

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = (state == ISSUE);
  assign head = mem[rd_ptr];

  always_ff @(posedge clk_ula) begin
    if (push) mem[wr_ptr] <= {bus.in_A, bus.in_B, bus.in_instru};
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    capture  = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE:  if (cnt != '0) begin load = 1'b1; state_nx = ISSUE; end
      // Opcode 00 answers combinationally, so the issue cycle can capture too.
      ISSUE: if (bus.valid_out) begin capture = 1'b1; state_nx = HOLD; end
             else state_nx = WAIT;
      WAIT:  if (bus.valid_out) begin capture = 1'b1; state_nx = HOLD; end
             else if (timer == 8'(TIMEOUT - 1)) begin abort = 1'b1; state_nx = GAP; end
      HOLD:  if (bus.res_ready) state_nx = GAP;
      GAP:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_ula) begin
    if (rst) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      cnt             <= '0;
      timer           <= '0;
      bus.A           <= '0;
      bus.B           <= '0;
      bus.instru      <= '0;
      bus.res_data    <= '0;
      bus.res_instru  <= '0;
      bus.timeout_err <= 1'b0;
    end else begin
      state           <= state_nx;
      bus.timeout_err <= abort;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: ;
      endcase
      // timer holds the number of completed WAIT cycles
      if (state == ISSUE)     timer <= '0;
      else if (state == WAIT) timer <= timer + 8'd1;
      if (load) begin
        bus.A      <= head.a;
        bus.B      <= head.b;
        bus.instru <= head.op;
      end
      if (capture) begin
        bus.res_data   <= bus.data_out;
        bus.res_instru <= bus.instru;
      end
    end
  end
endmodule

// File: tb/tb_ula_issue_queue.sv
// Directed bench for ula_issue_queue with a behavioural ULA that answers opcode k
// k cycles after issue (or never, when disabled).
module tb_ula_issue_queue;
  logic clk_ula = 1'b0;
  logic rst;
  logic ula_en;
  logic spur;

  ula_issue_queue_if #(.DEPTH(4)) bus();

  ula_issue_queue #(.DEPTH(4), .TIMEOUT(15)) dut (
    .clk_ula (clk_ula),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk_ula = ~clk_ula;

  // ---------------- ULA stub ----------------
  logic       busy = 1'b0;
  logic [1:0] rem  = 2'd0;

  function automatic logic [31:0] ula_calc(input logic [15:0] a, input logic [15:0] b,
                                           input logic [1:0] op);
    case (op)
      2'b00:   return {16'd0, a} + {16'd0, b};
      2'b01:   return (a >= b) ? {16'd0, a - b} : {16'd0, b - a};
      2'b10:   return {16'd0, a} + 32'd1;
      default: return {16'd0, b} + 32'd1;
    endcase
  endfunction

  always @(posedge clk_ula) begin
    if (busy) begin
      if (rem == 2'd0) busy <= 1'b0;
      else             rem  <= rem - 2'd1;
    end else if (ula_en && bus.valid_ula && bus.instru != 2'b00) begin
      busy <= 1'b1;
      rem  <= bus.instru - 2'd1;
    end
  end

  assign bus.valid_out = spur | (ula_en & bus.valid_ula & (bus.instru == 2'b00)) |
                         (busy & (rem == 2'd0));
  assign bus.data_out  = spur ? 32'hDEAD_BEEF : ula_calc(bus.A, bus.B, bus.instru);

  // ---------------- monitor ----------------
  int          cyc      = 0;
  int          iss_cnt  = 0;
  int          rv_cnt   = 0;
  int          hold_bad = 0;
  int          iss_q[$];
  int          to_q[$];
  logic [33:0] res_q[$];
  logic        prev_rv  = 1'b0;
  logic [33:0] prev_res = '0;

  always @(negedge clk_ula) begin
    cyc <= cyc + 1;
    if (bus.valid_ula) begin
      iss_cnt <= iss_cnt + 1;
      iss_q.push_back(cyc);
    end
    if (bus.timeout_err) to_q.push_back(cyc);
    if (bus.res_valid && !prev_rv) rv_cnt <= rv_cnt + 1;
    if (bus.res_valid && bus.res_ready) res_q.push_back({bus.res_instru, bus.res_data});
    if (prev_rv && bus.res_valid && ({bus.res_instru, bus.res_data} != prev_res))
      hold_bad <= hold_bad + 1;
    prev_rv  <= bus.res_valid;
    prev_res <= {bus.res_instru, bus.res_data};
  end

  // ---------------- checking helpers ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expire(input string nm);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  task automatic tick();
    @(posedge clk_ula);
    #1;
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    int n = 0;
    while (!bus.in_ready && n < 50) begin tick(); n++; end
    if (!bus.in_ready) expire("push_ready");
    bus.in_valid  = 1'b1;
    bus.in_A      = a;
    bus.in_B      = b;
    bus.in_instru = op;
    tick();
    bus.in_valid  = 1'b0;
  endtask

  task automatic wait_rv(output int n);
    n = 0;
    while (!bus.res_valid && n < 60) begin tick(); n++; end
    if (!bus.res_valid) expire("wait_res_valid");
  endtask

  task automatic wait_res(input int want);
    int n = 0;
    while (res_q.size() < want && n < 120) begin tick(); n++; end
    if (res_q.size() < want) expire("wait_results");
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_A"},           64'(bus.A), 0);
    chk({tag, "_B"},           64'(bus.B), 0);
    chk({tag, "_instru"},      64'(bus.instru), 0);
    chk({tag, "_valid_ula"},   64'(bus.valid_ula), 0);
    chk({tag, "_res_valid"},   64'(bus.res_valid), 0);
    chk({tag, "_res_data"},    64'(bus.res_data), 0);
    chk({tag, "_res_instru"},  64'(bus.res_instru), 0);
    chk({tag, "_timeout_err"}, 64'(bus.timeout_err), 0);
    chk({tag, "_count"},       64'(bus.count), 0);
    chk({tag, "_in_ready"},    64'(bus.in_ready), 1);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[7];

  initial begin
    int n, base_i, base_r, base_t, snap_i, snap_rv;

    vt[0] = '{16'd3,      16'd5,      2'b00, 32'd8};
    vt[1] = '{16'd2,      16'd9,      2'b01, 32'd7};
    vt[2] = '{16'hFFFF,   16'd0,      2'b10, 32'h0001_0000};
    vt[3] = '{16'd0,      16'd7,      2'b11, 32'd8};
    vt[4] = '{16'h8000,   16'h8000,   2'b00, 32'h0001_0000};
    vt[5] = '{16'd5,      16'd2,      2'b01, 32'd3};
    vt[6] = '{16'd0,      16'hFFFF,   2'b11, 32'h0001_0000};

    rst = 1'b1; ula_en = 1'b1; spur = 1'b0;
    bus.in_valid = 1'b0; bus.in_A = '0; bus.in_B = '0; bus.in_instru = '0;
    bus.res_ready = 1'b1;
    tick(); tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // single ops from the table, res_ready tied high
    for (int i = 0; i < 7; i++) begin
      snap_i = iss_cnt;
      push(vt[i].a, vt[i].b, vt[i].op);
      wait_rv(n);
      chk($sformatf("vec%0d_latency", i), 64'(n), 64'(vt[i].op) + 64'd2);
      chk($sformatf("vec%0d_res_data", i), 64'(bus.res_data), 64'(vt[i].exp));
      chk($sformatf("vec%0d_res_instru", i), 64'(bus.res_instru), 64'(vt[i].op));
      chk($sformatf("vec%0d_A_held", i), 64'(bus.A), 64'(vt[i].a));
      chk($sformatf("vec%0d_B_held", i), 64'(bus.B), 64'(vt[i].b));
      chk($sformatf("vec%0d_issues", i), 64'(iss_cnt - snap_i), 1);
      tick(); tick();
      chk($sformatf("vec%0d_count", i), 64'(bus.count), 0);
    end

    // back-to-back ops: ordering and issue spacing of k+4
    base_i = iss_q.size(); base_r = res_q.size();
    push(16'd2, 16'd9, 2'b01);
    push(16'hFFFF, 16'd0, 2'b10);
    push(16'd0, 16'd7, 2'b11);
    wait_res(base_r + 3);
    chk("b2b_n_results", 64'(res_q.size() - base_r), 3);
    chk("b2b_res0", 64'(res_q[base_r]),     64'h1_0000_0007);
    chk("b2b_res1", 64'(res_q[base_r + 1]), 64'h2_0001_0000);
    chk("b2b_res2", 64'(res_q[base_r + 2]), 64'h3_0000_0008);
    chk("b2b_gap01", 64'(iss_q[base_i + 1] - iss_q[base_i]), 5);
    chk("b2b_gap12", 64'(iss_q[base_i + 2] - iss_q[base_i + 1]), 6);
    tick(); tick();

    // fill the FIFO behind a held result
    bus.res_ready = 1'b0;
    base_r = res_q.size();
    push(16'd1, 16'd2, 2'b00);
    wait_rv(n);
    chk("full_hold_data", 64'(bus.res_data), 3);
    push(16'd10, 16'd4, 2'b01);
    push(16'd7, 16'd0, 2'b10);
    push(16'd0, 16'd0, 2'b11);
    push(16'd100, 16'd200, 2'b00);
    chk("full_count", 64'(bus.count), 4);
    chk("full_in_ready", 64'(bus.in_ready), 0);
    bus.in_valid = 1'b1; bus.in_A = 16'hFFFF; bus.in_B = 16'hFFFF; bus.in_instru = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("full_blk%0d_count", i), 64'(bus.count), 4);
      chk($sformatf("full_blk%0d_in_ready", i), 64'(bus.in_ready), 0);
      chk($sformatf("full_blk%0d_res", i), 64'({bus.res_valid, bus.res_instru, bus.res_data}),
          64'h4_0000_0003);
    end
    bus.res_ready = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 40) begin tick(); n++; end
    if (!bus.in_ready) expire("full_pop");
    tick();
    bus.in_valid = 1'b0;
    wait_res(base_r + 6);
    chk("full_res0", 64'(res_q[base_r]),     64'h0_0000_0003);
    chk("full_res1", 64'(res_q[base_r + 1]), 64'h1_0000_0006);
    chk("full_res2", 64'(res_q[base_r + 2]), 64'h2_0000_0008);
    chk("full_res3", 64'(res_q[base_r + 3]), 64'h3_0000_0001);
    chk("full_res4", 64'(res_q[base_r + 4]), 64'h0_0000_012C);
    chk("full_res5", 64'(res_q[base_r + 5]), 64'h0_0001_FFFE);
    tick(); tick();

    // watchdog: ULA silent for the first op, then the next one completes
    ula_en = 1'b0;
    base_i = iss_q.size(); base_r = res_q.size(); base_t = to_q.size();
    push(16'd1, 16'd1, 2'b01);
    push(16'd3, 16'd5, 2'b00);
    tick();
    chk("to_wait_A", 64'(bus.A), 1);
    chk("to_wait_instru", 64'(bus.instru), 1);
    n = 0;
    while (!bus.timeout_err && n < 40) begin tick(); n++; end
    if (!bus.timeout_err) expire("timeout_pulse");
    ula_en = 1'b1;
    wait_res(base_r + 1);
    tick(); tick(); tick();
    chk("to_pulses", 64'(to_q.size() - base_t), 1);
    chk("to_delay", 64'(to_q[base_t] - iss_q[base_i]), 16);
    chk("to_n_results", 64'(res_q.size() - base_r), 1);
    chk("to_next_res", 64'(res_q[base_r]), 64'h0_0000_0008);
    chk("to_issues", 64'(iss_q.size() - base_i), 2);

    // reset during WAIT with two ops queued
    push(16'd0, 16'd7, 2'b11);
    push(16'd1, 16'd1, 2'b00);
    push(16'd2, 16'd2, 2'b00);
    chk("rst_pre_count", 64'(bus.count), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outputs("midrst");
    snap_i = iss_cnt; snap_rv = rv_cnt;
    repeat (8) tick();
    chk("midrst_no_res", 64'(rv_cnt - snap_rv), 0);
    chk("midrst_no_issue", 64'(iss_cnt - snap_i), 0);
    chk("midrst_count", 64'(bus.count), 0);

    // spurious valid_out while idle and empty
    spur = 1'b1;
    tick(); tick();
    spur = 1'b0;
    tick();
    chk("spur_res_valid", 64'(bus.res_valid), 0);
    chk("spur_res_data", 64'(bus.res_data), 0);
    chk("spur_rv_events", 64'(rv_cnt - snap_rv), 0);
    chk("spur_issue", 64'(iss_cnt - snap_i), 0);
    push(16'd3, 16'd5, 2'b00);
    wait_rv(n);
    chk("post_latency", 64'(n), 2);
    chk("post_res_data", 64'(bus.res_data), 8);

    chk("hold_stable", 64'(hold_bad), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
